muldiv_sequencer: RTL and testbench

//  Iterative signed MULT/DIV engine and its sequencer, started by Control.

---
 rtl/muldiv_sequencer_if.sv | 39 +++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Control <-> mult/div sequencer bus: start request, operands, status strobes and HI/LO results.
// MULDIV_UNSIGNED_EN adds signed_op (0 selects MULTU/DIVU).
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
`ifdef MULDIV_UNSIGNED_EN
    logic             signed_op;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             div_mult;
    logic             reg_high_w;
    logic             reg_low_w;
    logic [WIDTH-1:0] high_out;
    logic [WIDTH-1:0] low_out;

    modport master (
        output
`ifdef MULDIV_UNSIGNED_EN
        signed_op,
`endif
        start, op, operand_a, operand_b,
        input  busy, done, div_zero, div_mult, reg_high_w, reg_low_w, high_out, low_out
    );

    modport slave (
        input
`ifdef MULDIV_UNSIGNED_EN
        signed_op,
`endif
        start, op, operand_a, operand_b,
        output busy, done, div_zero, div_mult, reg_high_w, reg_low_w, high_out, low_out
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT (shift-add) / DIV (restoring) engine with its sequencing FSM.
// MULDIV_UNSIGNED_EN enables the signed_op input for MULTU/DIVU.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    muldiv_sequencer_if.slave io_bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StFix, StWrite, StZero} state_e;

    state_e             r_state;
    logic [CntW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic               r_div_mult;
    logic               r_reg_w;
    logic [WIDTH-1:0]   r_high_out;
    logic [WIDTH-1:0]   r_low_out;

    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;

`ifdef MULDIV_UNSIGNED_EN
    logic r_signed;
    assign w_signed = r_signed;
`else
    assign w_signed = 1'b1;
`endif

    assign w_sign_a = w_signed & r_a[WIDTH-1];
    assign w_sign_b = w_signed & r_b[WIDTH-1];
    assign w_abs_a  = w_sign_a ? -r_a : r_a;
    assign w_abs_b  = w_sign_b ? -r_b : r_b;

    // Mult: {r_hi, r_lo} is the product/multiplier pair shifted right each step.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    // Div: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = w_shift >= {1'b0, r_b};
    assign w_diff   = w_shift - {1'b0, r_b};
    assign w_prod   = r_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_mult <= 1'b0;
            r_reg_w    <= 1'b0;
            r_high_out <= '0;
            r_low_out  <= '0;
`ifdef MULDIV_UNSIGNED_EN
            r_signed   <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_reg_w    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_div_mult <= io_bus.op;
                        r_a        <= io_bus.operand_a;
                        r_b        <= io_bus.operand_b;
`ifdef MULDIV_UNSIGNED_EN
                        r_signed   <= io_bus.signed_op;
`endif
                        if (!io_bus.op && io_bus.operand_b == '0) begin
                            r_state    <= StZero;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= StLoad;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    r_a       <= w_abs_a;
                    r_b       <= w_abs_b;
                    r_hi      <= '0;
                    r_lo      <= r_div_mult ? w_abs_b : w_abs_a;
                    r_neg_res <= w_sign_a ^ w_sign_b;
                    r_neg_rem <= w_sign_a;
                    r_cnt     <= CntW'(WIDTH - 1);
                    r_state   <= StRun;
                end
                StRun: begin
                    if (r_div_mult) begin
                        r_hi <= w_sum[WIDTH:1];
                        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
                    end else begin
                        r_hi <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], w_ge};
                    end
                    r_cnt <= r_cnt - CntW'(1);
                    if (r_cnt == '0) begin
                        r_state <= StFix;
                    end
                end
                StFix: begin
                    if (r_div_mult) begin
                        r_high_out <= w_prod[2*WIDTH-1:WIDTH];
                        r_low_out  <= w_prod[WIDTH-1:0];
                    end else begin
                        r_high_out <= r_neg_rem ? -r_hi : r_hi;
                        r_low_out  <= r_neg_res ? -r_lo : r_lo;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_reg_w <= 1'b1;
                    r_state <= StWrite;
                end
                StWrite: r_state <= StIdle;
                StZero:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
    assign io_bus.div_zero   = r_div_zero;
    assign io_bus.div_mult   = r_div_mult;
    assign io_bus.reg_high_w = r_reg_w;
    assign io_bus.reg_low_w  = r_reg_w;
    assign io_bus.high_out   = r_high_out;
    assign io_bus.low_out    = r_low_out;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus randomized MULT/DIV.
// Expected results come from plain 64-bit arithmetic; a negedge monitor checks each Done.
module tb_muldiv_sequencer;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 3;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        dm;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus_if ();
    muldiv_sequencer #(.WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_if));

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          busy_from = 0;
    int          busy_to = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                   input logic sgn);
        exp_t        e;
        longint      sa, sb, p, qq, rr;
        logic [63:0] up;
        e = '0;
        e.dm = op;
        sa = $signed(a);
        sb = $signed(b);
        if (op) begin
            if (sgn) begin
                p = sa * sb;
                {e.hi, e.lo} = p;
            end else begin
                up = {32'd0, a} * {32'd0, b};
                {e.hi, e.lo} = up;
            end
        end else if (b == 32'd0) begin
            e.dz = 1'b1;
            e.hi = last_hi;
            e.lo = last_lo;
        end else if (sgn) begin
            qq = sa / sb;
            rr = sa % sb;
            e.lo = qq[31:0];
            e.hi = rr[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {63'd0, bus_if.busy}, {63'd0, (cyc >= busy_from && cyc < busy_to)});
            if (bus_if.done) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, required done=0", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    n_vec++;
                    check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("hi", {32'd0, bus_if.high_out}, {32'd0, mon_e.hi});
                    check("lo", {32'd0, bus_if.low_out}, {32'd0, mon_e.lo});
                    check("div_zero", {63'd0, bus_if.div_zero}, {63'd0, mon_e.dz});
                    check("div_mult", {63'd0, bus_if.div_mult}, {63'd0, mon_e.dm});
                    check("reg_w", {62'd0, bus_if.reg_high_w, bus_if.reg_low_w},
                          {62'd0, !mon_e.dz, !mon_e.dz});
                end
            end else begin
                check("idle_strobes", {61'd0, bus_if.div_zero, bus_if.reg_high_w,
                      bus_if.reg_low_w}, 64'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_start(input logic op, input logic [31:0] a, input logic [31:0] b,
                               input logic sgn);
        bus_if.start     = 1'b1;
        bus_if.op        = op;
        bus_if.operand_a = a;
        bus_if.operand_b = b;
`ifdef MULDIV_UNSIGNED_EN
        bus_if.signed_op = sgn;
`endif
    endtask

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input bit noise);
        exp_t e;
        int   target;
        e = model(op, a, b, sgn);
        e.cyc = cyc + (e.dz ? 1 : LAT);
        if (!e.dz) begin
            busy_from = cyc + 1;
            busy_to   = cyc + LAT;
            last_hi   = e.hi;
            last_lo   = e.lo;
        end
        sb_q.push_back(e);
        target = n_done + 1;
        drive_start(op, a, b, sgn);
        step();
        bus_if.start     = 1'b0;
        bus_if.operand_a = $urandom;
        bus_if.operand_b = $urandom;
        for (int k = 1; k < LAT + 8; k++) begin
            if (n_done >= target) break;
            // A div-by-zero request here would finish at once if it were wrongly accepted.
            if (noise && (k == 5 || k == 20)) drive_start(1'b0, 32'd9, 32'd0, 1'b1);
            else bus_if.start = 1'b0;
            step();
        end
        bus_if.start = 1'b0;
        if (n_done < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout at cycle %0d: got no done, required done", cyc);
            sb_q.delete();
        end
        step();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($signed($urandom_range(0, 200)) - 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        op, sgn;
        logic [31:0] a, b;
        bus_if.start     = 1'b0;
        bus_if.op        = 1'b0;
        bus_if.operand_a = '0;
        bus_if.operand_b = '0;
`ifdef MULDIV_UNSIGNED_EN
        bus_if.signed_op = 1'b1;
`endif
        #1;
        check("rst_outputs", {bus_if.high_out, bus_if.low_out}, 64'd0);
        check("rst_flags", {58'd0, bus_if.busy, bus_if.done, bus_if.div_zero, bus_if.div_mult,
              bus_if.reg_high_w, bus_if.reg_low_w}, 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        issue(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        issue(1'b0, 32'd5, 32'd0, 1'b1, 1'b0);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(1'b1, 32'd12345, 32'hFFFF_E000, 1'b1, 1'b1);

        // Abort a MULT mid-flight: nothing is scoreboarded, so any Done is flagged.
        busy_from = cyc + 1;
        busy_to   = cyc + LAT;
        drive_start(1'b1, 32'd1000, 32'd1000, 1'b1);
        step();
        bus_if.start = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        busy_to = 0;
        last_hi = '0;
        last_lo = '0;
        check("abort_outputs", {bus_if.high_out, bus_if.low_out}, 64'd0);
        check("abort_flags", {58'd0, bus_if.busy, bus_if.done, bus_if.div_zero, bus_if.div_mult,
              bus_if.reg_high_w, bus_if.reg_low_w}, 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (LAT + 5) step();
        issue(1'b0, 32'd3, 32'd0, 1'b1, 1'b0);

`ifdef MULDIV_UNSIGNED_EN
        issue(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            op  = 1'($urandom_range(0, 1));
            a   = pick();
            b   = pick();
`ifdef MULDIV_UNSIGNED_EN
            sgn = 1'($urandom_range(0, 1));
`else
            sgn = 1'b1;
`endif
            issue(op, a, b, sgn, 1'($urandom_range(0, 3) == 0));
        end

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
